// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel to one registered mux with valid/ready handshake.
// MODE=0 picks the channel named by sel; MODE=1 arbitrates round-robin.
// Output is a single EMPTY/FULL register that can be reloaded every cycle.

module mux_arb_n_lane #(
  parameter int SW  = 2,
  parameter int IDX = 0
) (
  input  logic          grant_en,
  input  logic [SW-1:0] cand,
  output logic          ready
);
  assign ready = grant_en && (cand == SW'(IDX));
endmodule

module mux_arb_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0,
  localparam int SW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SW-1:0]             sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SW-1:0]             out_chan,
  output logic                      err_sel
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                             state, state_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0]     lanes;
  logic [SW-1:0]                      ptr;
  logic [SW-1:0]                      cand;
  logic                               cand_ok;
  logic                               load_en;
  logic                               grant_en;
  logic                               xfer;

  assign lanes     = in_data;
  assign out_valid = (state == FULL);
  assign load_en   = !out_valid || out_ready;
  // Reset blocks any grant so nothing is accepted while it is held.
  assign grant_en  = load_en && cand_ok && !reset;
  assign xfer      = grant_en && in_valid[cand];

  // Candidate channel: external select, or first valid after the last grant.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (MODE == 0) begin
      cand    = sel;
      cand_ok = (int'(sel) < CHANNELS);
    end else begin
      // Walk farthest-first so the nearest valid channel after ptr wins.
      for (int k = CHANNELS; k >= 1; k--) begin
        int j;
        j = int'(ptr) + k;
        if (j >= CHANNELS) j = j - CHANNELS;
        if (in_valid[SW'(j)]) begin
          cand    = SW'(j);
          cand_ok = 1'b1;
        end
      end
    end
  end

  // One-hot accept strobe, one lane instance per channel.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    mux_arb_n_lane #(.SW(SW), .IDX(i)) u_lane (
      .grant_en (grant_en),
      .cand     (cand),
      .ready    (in_ready[i])
    );
  end

  // Output register state: reload whenever the slot is free or draining.
  always_comb begin
    state_nxt = state;
    if (load_en) state_nxt = xfer ? FULL : EMPTY;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Captured word and its source channel; held when nothing is transferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_chan <= '0;
    end else if (xfer) begin
      out_data <= lanes[cand];
      out_chan <= cand;
    end
  end

  // Round-robin pointer; reset value makes channel 0 the first grant.
  always_ff @(posedge clk) begin
    if (reset)                   ptr <= SW'(CHANNELS - 1);
    else if (xfer && MODE == 1)  ptr <= cand;
  end

  // Sticky out-of-range select flag, only meaningful with external select.
  always_ff @(posedge clk) begin
    if (reset)                                  err_sel <= 1'b0;
    else if (MODE == 0 && load_en && !cand_ok)  err_sel <= 1'b1;
  end

endmodule

// File: tb/tb_mux_arb_n.sv
// Bench for mux_arb_n: three instances (select/4ch, round-robin/4ch,
// select/3ch) share one stimulus stream and are compared every cycle with a
// behavioural model, plus directed checks of the documented scenarios.

module tb_mux_arb_n;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  rdy [3];
  logic [15:0] dat [3];
  logic        vld [3];
  logic [1:0]  chn [3];
  logic        err [3];
  logic [2:0]  rdy2;

  int checks = 0;
  int errors = 0;

  // model state per instance
  int          nch [3] = '{4, 4, 3};
  int          mmd [3] = '{0, 1, 0};
  logic [15:0] md  [3];
  logic        mv  [3];
  int          mc  [3];
  logic        me  [3];
  int          mp  [3];

  always #5 clk = ~clk;

  mux_arb_n #(.WIDTH(16), .CHANNELS(4), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .sel(sel), .out_data(dat[0]), .out_valid(vld[0]),
    .out_ready(out_ready), .out_chan(chn[0]), .err_sel(err[0]));

  mux_arb_n #(.WIDTH(16), .CHANNELS(4), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .sel(sel), .out_data(dat[1]), .out_valid(vld[1]),
    .out_ready(out_ready), .out_chan(chn[1]), .err_sel(err[1]));

  mux_arb_n #(.WIDTH(16), .CHANNELS(3), .MODE(0)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data[47:0]), .in_valid(in_valid[2:0]),
    .in_ready(rdy2), .sel(sel), .out_data(dat[2]), .out_valid(vld[2]),
    .out_ready(out_ready), .out_chan(chn[2]), .err_sel(err[2]));

  assign rdy[2] = {1'b0, rdy2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel the spec says should be offered this cycle, -1 if none.
  function automatic int cand_of(int u);
    if (mmd[u] == 0) return (int'(sel) < nch[u]) ? int'(sel) : -1;
    for (int k = 1; k <= nch[u]; k++) begin
      int i;
      i = (mp[u] + k) % nch[u];
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic int exp_rdy(int u);
    int c;
    c = cand_of(u);
    if (reset || !(!mv[u] || out_ready) || c < 0) return 0;
    return 1 << c;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      md[u] = '0; mv[u] = 1'b0; mc[u] = 0; me[u] = 1'b0; mp[u] = nch[u] - 1;
    end
  endtask

  // One clock: check strobes before the edge, advance model, check outputs.
  task automatic step();
    int   c  [3];
    logic le [3];
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("in_ready[u%0d]", u), 32'(rdy[u]), 32'(exp_rdy(u)));
      c[u]  = cand_of(u);
      le[u] = !mv[u] || out_ready;
    end
    @(posedge clk);
    if (reset) model_reset();
    else begin
      for (int u = 0; u < 3; u++) begin
        if (le[u]) begin
          if (c[u] >= 0 && in_valid[c[u]]) begin
            md[u] = in_data[c[u]*16 +: 16];
            mv[u] = 1'b1;
            mc[u] = c[u];
            if (mmd[u] == 1) mp[u] = c[u];
          end else begin
            mv[u] = 1'b0;
          end
          if (mmd[u] == 0 && int'(sel) >= nch[u]) me[u] = 1'b1;
        end
      end
    end
    #1;
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("out_data[u%0d]", u),  32'(dat[u]), 32'(md[u]));
      chk($sformatf("out_valid[u%0d]", u), 32'(vld[u]), 32'(mv[u]));
      chk($sformatf("out_chan[u%0d]", u),  32'(chn[u]), 32'(mc[u]));
      chk($sformatf("err_sel[u%0d]", u),   32'(err[u]), 32'(me[u]));
    end
  endtask

  int rr_all [6] = '{0, 1, 2, 3, 0, 1};
  int rr_odd [4] = '{1, 3, 1, 3};

  initial begin
    reset = 1'b1; in_data = '0; in_valid = '0; sel = '0; out_ready = 1'b0;
    model_reset();
    step(); step();
    // reset state
    chk("rst_out_valid", 32'(vld[0]), 0);
    chk("rst_out_data",  32'(dat[1]), 0);
    chk("rst_err_sel",   32'(err[2]), 0);

    // external select: sel=1 then 2
    reset = 1'b0;
    in_data = {16'h5555, 16'd12, 16'd3, 16'hAAAA};
    in_valid = 4'hF; out_ready = 1'b1; sel = 2'd1;
    step();
    chk("sel1_data", 32'(dat[0]), 3);
    chk("sel1_chan", 32'(chn[0]), 1);
    sel = 2'd2;
    step();
    chk("sel2_data", 32'(dat[0]), 12);
    chk("sel2_chan", 32'(chn[0]), 2);

    // backpressure: hold 12 while ch2 changes to 7
    out_ready = 1'b0;
    in_data[47:32] = 16'd7;
    repeat (3) begin
      step();
      chk("bp_hold_data", 32'(dat[0]), 12);
      chk("bp_in_ready",  32'(rdy[0]), 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_data", 32'(dat[0]), 7);

    // round-robin from reset, all valid
    reset = 1'b1; step();
    reset = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rr_all_chan", 32'(chn[1]), 32'(rr_all[i]));
    end
    // only ch1 and ch3 valid, from a fresh reset
    reset = 1'b1; step();
    reset = 1'b0; in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_odd_chan", 32'(chn[1]), 32'(rr_odd[i]));
    end

    // out-of-range select on the 3-channel instance
    in_valid = 4'hF; sel = 2'd0;
    step();
    chk("oor_pre_valid", 32'(vld[2]), 1);
    sel = 2'd3;
    #1;
    chk("oor_in_ready", 32'(rdy[2]), 0);
    step();
    chk("oor_valid_fall", 32'(vld[2]), 0);
    chk("oor_err_set",    32'(err[2]), 1);
    sel = 2'd0;
    step(); step();
    chk("oor_err_sticky", 32'(err[2]), 1);
    chk("err_mode1_zero", 32'(err[1]), 0);

    // reset while FULL and stalled
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("rst_full_valid", 32'(vld[2]), 0);
    chk("rst_full_data",  32'(dat[0]), 0);
    chk("rst_full_chan",  32'(chn[1]), 0);
    chk("rst_full_err",   32'(err[2]), 0);
    reset = 1'b0; out_ready = 1'b1; in_valid = 4'hF;
    step();
    chk("rr_first_after_rst", 32'(chn[1]), 0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
